// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the control, instruction-memory and decode handshake signals of the fetch sequencer.
//    start/redirect_valid/redirect_addr  control into the sequencer
//    imem_addr/imem_instr                instruction memory address out, read data back (1-cycle latency)
//    instr_valid/instr_ready             valid/ready handshake towards decode
//    instr_data/instr_pc                 head instruction and its PC
//    busy/halted                         fetch status
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 8
);
   logic               start;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic               busy;
   logic               halted;
   modport master (
      input  start, redirect_valid, redirect_addr, imem_instr, instr_ready,
      output imem_addr, instr_valid, instr_data, instr_pc, busy, halted
   );
   modport slave (
      output start, redirect_valid, redirect_addr, imem_instr, instr_ready,
      input  imem_addr, instr_valid, instr_data, instr_pc, busy, halted
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches one instruction per cycle from a registered memory and hands PC-tagged instructions to decode.
//    clk    system clock, all state on posedge
//    reset  synchronous, active-low
//    bus    fetch_sequencer_if.master (memory port, decode handshake, start/redirect, status)
module fetch_sequencer #(
   parameter int                ADDR_W     = 8,
   parameter int                INSTR_W    = 8,
   parameter int                DEPTH      = 2,
   parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
   parameter logic [INSTR_W-1:0] HALT_OP   = 8'hFF
) (
   input logic               clk,
   input logic               reset,
   fetch_sequencer_if.master bus
);
   localparam int CW = $clog2(DEPTH + 2) + 1;
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, inflight_pc;
   logic               inflight_q;
   logic [INSTR_W-1:0] fifo_d [DEPTH];
   logic [ADDR_W-1:0]  fifo_p [DEPTH];
   logic [PW-1:0]      rd_q, wr_q, rd_n, wr_n;
   logic [CW-1:0]      count_q, occ;
   logic               valid, pop, halt_accept, flush, issue, push, fetching, starting;
   always_comb begin
      fetching    = state_q == FETCH;
      starting    = !fetching && bus.start;
      valid       = count_q != '0;
      pop         = valid && bus.instr_ready;
      halt_accept = fetching && pop && fifo_d[rd_q] == HALT_OP;
      flush       = fetching && (bus.redirect_valid || halt_accept);
      // credit: every in-flight return must already own a free FIFO slot
      occ         = count_q + CW'(inflight_q) - CW'(pop);
      issue       = fetching && !bus.redirect_valid && !halt_accept && occ < CW'(DEPTH);
      push        = inflight_q && !flush;
      rd_n        = rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
      wr_n        = wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
      state_d     = starting ? FETCH : halt_accept ? HALT : state_q;
      // halt beats redirect, so pc holds when both land together
      pc_d        = starting ? START_ADDR :
                    halt_accept ? pc_q :
                    fetching && bus.redirect_valid ? bus.redirect_addr :
                    issue ? pc_q + 1'b1 : pc_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= START_ADDR;
         inflight_q  <= 1'b0;
         inflight_pc <= '0;
         count_q     <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) inflight_pc <= pc_q;
         if (push) begin
            fifo_d[wr_q] <= bus.imem_instr;
            fifo_p[wr_q] <= inflight_pc;
         end
         if (flush) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
         end else begin
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push) wr_q <= wr_n;
            if (pop) rd_q <= rd_n;
         end
      end
   end
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr_data  = valid ? fifo_d[rd_q] : '0;
   assign bus.instr_pc    = valid ? fifo_p[rd_q] : '0;
   assign bus.busy        = fetching;
   assign bus.halted      = state_q == HALT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a queue-based transaction model.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   fetch_sequencer_if bus ();
   fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
   logic [7:0] mem [256];
   always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr];
   int vectors = 0;
   int miscompares = 0;
   // reference model: a running/halted mode, the PC, one pending read and a queue of {instr, pc}
   bit          known = 0;
   bit          run_m, halt_m, infl_m;
   logic [7:0]  pc_m, infl_pc_m, infl_ins_m;
   logic [15:0] q_m [$];
   logic [7:0]  seen [$];
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input bit rst_n, input bit st, input bit rv, input logic [7:0] ra, input bit rdy);
      bit pop, hacc, iss;
      reset              = rst_n;
      bus.start          = st;
      bus.redirect_valid = rv;
      bus.redirect_addr  = ra;
      bus.instr_ready    = rdy;
      #1;
      if (known) begin
         chk("imem_addr", 16'(bus.imem_addr), 16'(pc_m));
         chk("instr_valid", 16'(bus.instr_valid), 16'(q_m.size() > 0));
         chk("instr_data", 16'(bus.instr_data), q_m.size() > 0 ? 16'(q_m[0][15:8]) : 16'h0);
         chk("instr_pc", 16'(bus.instr_pc), q_m.size() > 0 ? 16'(q_m[0][7:0]) : 16'h0);
         chk("busy", 16'(bus.busy), 16'(run_m));
         chk("halted", 16'(bus.halted), 16'(halt_m));
      end
      @(posedge clk);
      if (!rst_n) begin
         known  = 1;
         run_m  = 0;
         halt_m = 0;
         infl_m = 0;
         pc_m   = 8'h00;
         q_m.delete();
      end else if (known) begin
         pop  = q_m.size() > 0 && rdy;
         hacc = run_m && pop && q_m[0][15:8] == 8'hFF;
         iss  = run_m && !rv && !hacc && (q_m.size() + int'(infl_m) - int'(pop) < 2);
         if (pop) seen.push_back(q_m[0][7:0]);
         if (pop) void'(q_m.pop_front());
         if (run_m && (rv || hacc)) q_m.delete();
         else if (infl_m) q_m.push_back({infl_ins_m, infl_pc_m});
         infl_m = iss;
         if (iss) begin
            infl_pc_m  = pc_m;
            infl_ins_m = mem[pc_m];
         end
         if (!run_m && st) begin
            run_m  = 1;
            halt_m = 0;
            pc_m   = 8'h00;
         end else if (hacc) begin
            run_m  = 0;
            halt_m = 1;
         end else if (run_m && rv) pc_m = ra;
         else if (iss) pc_m = pc_m + 8'd1;
      end
      @(negedge clk);
   endtask
   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
      // 1: reset, start, streaming with ready high
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 1, 8'h33, 1);
      chk("rst_addr", 16'(bus.imem_addr), 16'h0000);
      chk("rst_valid", 16'(bus.instr_valid), 16'h0000);
      chk("rst_busy", 16'(bus.busy), 16'h0000);
      cyc(1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      chk("first_gap", 16'(bus.instr_valid), 16'h0000);
      cyc(1, 0, 0, 0, 1);
      chk("first_valid", 16'(bus.instr_valid), 16'h0001);
      chk("first_data", 16'(bus.instr_data), 16'h0001);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
      // 2: decode stalls, then resumes
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
      // 3: redirect with data buffered and in flight
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 8'h40, 0);
      n = 0;
      while (!bus.instr_valid && n < 10) begin
         cyc(1, 0, 0, 0, 0);
         n++;
      end
      chk("redir_pc", 16'(bus.instr_pc), 16'h0040);
      chk("redir_lat", 16'(n), 16'd2);
      for (int i = 0; i < 60; i++)
         cyc(1, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             8'($urandom_range(8'h10, 8'h3F)), $urandom_range(0, 9) < 7);
      // 4: halt on opcode at pc 5
      mem[5] = 8'hFF;
      cyc(1, 0, 1, 8'h00, 1);
      n = 0;
      while (!bus.halted && n < 20) begin
         cyc(1, 0, 0, 0, 1);
         n++;
      end
      chk("halted", 16'(bus.halted), 16'h0001);
      chk("halt_busy", 16'(bus.busy), 16'h0000);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h20, 1);
      mem[5] = 8'h06;
      cyc(1, 1, 0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
      // 5: wrap-around from 8'hFE
      for (int i = 0; i < 256; i++) mem[i] = 8'h11;
      cyc(1, 0, 1, 8'hFE, 1);
      seen.delete();
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 1);
      chk("wrap_cnt", 16'(seen.size() >= 4), 16'h0001);
      if (seen.size() >= 4) begin
         chk("wrap0", 16'(seen[0]), 16'h00FE);
         chk("wrap1", 16'(seen[1]), 16'h00FF);
         chk("wrap2", 16'(seen[2]), 16'h0000);
         chk("wrap3", 16'(seen[3]), 16'h0001);
      end
      // 6: reset mid-stream while valid
      cyc(1, 0, 0, 0, 0);
      chk("pre_rst_valid", 16'(bus.instr_valid), 16'h0001);
      cyc(0, 1, 1, 8'h20, 1);
      chk("rst_mid_valid", 16'(bus.instr_valid), 16'h0000);
      chk("rst_mid_pc", 16'(bus.instr_pc), 16'h0000);
      chk("rst_mid_halted", 16'(bus.halted), 16'h0000);
      // randomized soak with random memory, halts, restarts and resets
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
      for (int i = 0; i < 4; i++) mem[$urandom_range(0, 255)] = 8'hFF;
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0,
             8'($urandom), $urandom_range(0, 9) < 7);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
